// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_reader
// Brief    : Polls a physical NES controller pad. Drives LATCH/CLK, shifts in
//            the 8 active-low button bits from DATA and presents them as an
//            active-high byte with a one-cycle valid pulse per frame.
// Options  : NES_PAD_DEBOUNCE_EN - update buttons only when two consecutive
//            frames agree.
// Revision : 1.0 - initial release
// ============================================================================
module nes_pad_reader #(
  parameter int HALF_PERIOD = 128,
  parameter int POLL_PERIOD = 357954
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data,
  output logic [7:0] buttons,
  output logic       valid
);

  localparam int PH_W   = $clog2(2 * HALF_PERIOD);
  localparam int POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [PH_W-1:0]   C_H_LAST    = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]   C_2H_LAST   = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [POLL_W-1:0] C_POLL_LAST = POLL_W'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [2:0]          bit_q, bit_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [7:0]          raw_q, raw_d;
  logic [7:0]          buttons_q, buttons_d;
  logic                valid_q, valid_d;
  logic                latch_q, latch_d;
  logic                pclk_q, pclk_d;
  logic [1:0]          sync_q;
  logic                data_s;
`ifdef NES_PAD_DEBOUNCE_EN
  // [8] = previous frame captured since reset, [7:0] = its raw byte
  logic [8:0]          prev_q, prev_d;
`endif

  assign data_s    = sync_q[1];
  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;

  // Two-flop synchronizer for the asynchronous pad DATA line; idles released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pad_data};
    end
  end

  // State, counters and registered pad/host outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_q     <= 3'd0;
      poll_q    <= '0;
      raw_q     <= 8'h00;
      buttons_q <= 8'h00;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_q    <= 9'h000;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      poll_q    <= poll_d;
      raw_q     <= raw_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_q    <= prev_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, bit capture and result publication.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    raw_d     = raw_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
    prev_d    = prev_q;
`endif
    // Poll counter free-runs, including while a frame is in flight.
    poll_d = (poll_q == C_POLL_LAST) ? '0 : poll_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (poll_q == '0) begin
          state_d = S_LATCH;
          phase_d = '0;
        end
      end
      S_LATCH: begin
        if (phase_q == C_2H_LAST) begin
          state_d = S_LOW;
          phase_d = '0;
          bit_d   = 3'd0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LOW: begin
        if (phase_q == C_H_LAST) begin
          // Sample on the last LOW cycle, just before the next rising CLK.
          raw_d[bit_q] = ~data_s;
          state_d      = S_HIGH;
          phase_d      = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_q == C_H_LAST) begin
          phase_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = S_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
`ifdef NES_PAD_DEBOUNCE_EN
        if (prev_q[8] && (prev_q[7:0] == raw_q)) begin
          buttons_d = raw_q;
        end
        prev_d = {1'b1, raw_q};
`else
        buttons_d = raw_q;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pad lines are registered from the next state so they align with it.
    latch_d = (state_d == S_LATCH);
    pclk_d  = (state_d == S_HIGH);
  end

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
`default_nettype none
module tb_nes_pad_reader;

  localparam int H    = 4;
  localparam int POLL = 100;
`ifdef NES_PAD_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data;
  logic [7:0] buttons;
  logic       valid;

  // Pad model: 4021-style shift register, active-low outputs.
  logic [7:0] pad_pressed = 8'h00;
  logic [7:0] pad_sr      = 8'hFF;
  logic       ovr_en      = 1'b0;
  logic       ovr_val     = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .HALF_PERIOD(H),
    .POLL_PERIOD(POLL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .pad_data (pad_data),
    .buttons  (buttons),
    .valid    (valid)
  );

  always @(posedge pad_latch) pad_sr = ~pad_pressed;
  always @(posedge pad_clk) if (!pad_latch) pad_sr = {1'b1, pad_sr[7:1]};
  assign pad_data = ovr_en ? ovr_val : pad_sr[0];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  // Drop reset; the next edge is the first active one and marks cycle 0.
  task automatic release_rst();
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic restart();
    rst = 1'b1;
    step();
    step();
    release_rst();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 150; i++) begin
      step();
      if (i % 15 == 0) begin
        checks++;
        if ({pad_latch, pad_clk, valid, buttons} !== 11'h000) begin
          failures++;
          $display("FAIL reset_hold i=%0d: latch/clk/valid/buttons=%b/%b/%b/%h required 0/0/0/00",
                   i, pad_latch, pad_clk, valid, buttons);
        end
      end
    end
  endtask

  task automatic test_idle_frame();
    logic exp_l, exp_c, exp_v;
    logic prev_clk;
    int   rises;
    prev_clk    = 1'b0;
    rises       = 0;
    pad_pressed = 8'h00;
    release_rst();
    for (int c = 0; c <= POLL; c++) begin
      if (c > 0) step();
      exp_l = (c < 2 * H) || (c == POLL);
      exp_c = (c >= 12) && (c <= 71) && (((c - 12) % 8) < 4);
      exp_v = (c == 73);
      checks++;
      if ({pad_latch, pad_clk, valid, buttons} !== {exp_l, exp_c, exp_v, 8'h00}) begin
        failures++;
        $display("FAIL idle_frame cycle %0d: latch/clk/valid/buttons=%b/%b/%b/%h required %b/%b/%b/00",
                 c, pad_latch, pad_clk, valid, buttons, exp_l, exp_c, exp_v);
      end
      if (c < POLL) begin
        if (pad_clk && !prev_clk) rises++;
        prev_clk = pad_clk;
      end
    end
    checks++;
    if (rises !== 8) begin
      failures++;
      $display("FAIL idle_clk_pulses: got %0d required 8", rises);
    end
  endtask

  task automatic test_buttons(input logic [7:0] pressed);
    logic [7:0] exp1;
    exp1        = DB ? 8'h00 : pressed;
    pad_pressed = pressed;
    restart();
    goto(72);
    checks++;
    if ({valid, buttons} !== 9'h000) begin
      failures++;
      $display("FAIL buttons_%h_pre: valid/buttons=%b/%h required 0/00", pressed, valid, buttons);
    end
    goto(73);
    checks++;
    if ({valid, buttons} !== {1'b1, exp1}) begin
      failures++;
      $display("FAIL buttons_%h_f1: valid/buttons=%b/%h required 1/%h", pressed, valid, buttons, exp1);
    end
    goto(74);
    checks++;
    if ({valid, buttons} !== {1'b0, exp1}) begin
      failures++;
      $display("FAIL buttons_%h_hold: valid/buttons=%b/%h required 0/%h", pressed, valid, buttons, exp1);
    end
    goto(173);
    checks++;
    if ({valid, buttons} !== {1'b1, pressed}) begin
      failures++;
      $display("FAIL buttons_%h_f2: valid/buttons=%b/%h required 1/%h", pressed, valid, buttons, pressed);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp1;
    exp1        = DB ? 8'h00 : 8'h09;
    pad_pressed = 8'h09;
    restart();
    goto(73);
    checks++;
    if (buttons !== exp1) begin
      failures++;
      $display("FAIL midrst_first: buttons=%h required %h", buttons, exp1);
    end
    goto(139);
    checks++;
    if (pad_clk !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre_clk: pad_clk=%b required 1", pad_clk);
    end
    goto(140);
    rst = 1'b1;
    step();
    checks++;
    if ({pad_latch, pad_clk, valid, buttons} !== 11'h000) begin
      failures++;
      $display("FAIL midrst_outputs: latch/clk/valid/buttons=%b/%b/%b/%h required 0/0/0/00",
               pad_latch, pad_clk, valid, buttons);
    end
    release_rst();
    checks++;
    if (pad_latch !== 1'b1) begin
      failures++;
      $display("FAIL midrst_restart_latch: pad_latch=%b required 1", pad_latch);
    end
    while (cyc < 72) begin
      step();
      checks++;
      if (valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_no_valid cycle %0d: valid=%b required 0", cyc, valid);
      end
    end
    goto(73);
    checks++;
    if ({valid, buttons} !== {1'b1, exp1}) begin
      failures++;
      $display("FAIL midrst_new_frame: valid/buttons=%b/%h required 1/%h", valid, buttons, exp1);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] exp2;
    exp2        = DB ? 8'h00 : 8'hFF;
    pad_pressed = 8'h00;
    restart();
    goto(73);
    checks++;
    if ({valid, buttons} !== 9'h100) begin
      failures++;
      $display("FAIL toggle_f1: valid/buttons=%b/%h required 1/00", valid, buttons);
    end
    pad_pressed = 8'hFF;
    goto(173);
    checks++;
    if ({valid, buttons} !== {1'b1, exp2}) begin
      failures++;
      $display("FAIL toggle_f2: valid/buttons=%b/%h required 1/%h", valid, buttons, exp2);
    end
    goto(273);
    checks++;
    if ({valid, buttons} !== 9'h1FF) begin
      failures++;
      $display("FAIL toggle_f3: valid/buttons=%b/%h required 1/ff", valid, buttons);
    end
  endtask

  // Hold DATA low during exactly one cycle.
  task automatic glitch_at(input int c);
    goto(c);
    ovr_val = 1'b0;
    ovr_en  = 1'b1;
    step();
    ovr_en  = 1'b0;
  endtask

  task automatic test_glitch();
    logic [7:0] exp3;
    exp3        = DB ? 8'h00 : 8'h01;
    pad_pressed = 8'h00;
    restart();
    glitch_at(6);
    goto(73);
    checks++;
    if (buttons !== 8'h00) begin
      failures++;
      $display("FAIL glitch_early_f1: buttons=%h required 00", buttons);
    end
    glitch_at(106);
    goto(173);
    checks++;
    if (buttons !== 8'h00) begin
      failures++;
      $display("FAIL glitch_early_f2: buttons=%h required 00", buttons);
    end
    glitch_at(209);
    goto(273);
    checks++;
    if (buttons !== exp3) begin
      failures++;
      $display("FAIL glitch_late_f3: buttons=%h required %h", buttons, exp3);
    end
    glitch_at(309);
    goto(373);
    checks++;
    if (buttons !== 8'h01) begin
      failures++;
      $display("FAIL glitch_late_f4: buttons=%h required 01", buttons);
    end
  endtask

  initial begin
    test_reset();
    test_idle_frame();
    test_buttons(8'h09);
    test_buttons(8'h80);
    test_mid_reset();
    test_toggle();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
